// File: rtl/freq_div_pkg.sv
// freq_div_pkg: shared state type, minimum divisor and divisor clamp for the programmable divider
package freq_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  localparam int MIN_DIV = 2;
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
  endfunction
endpackage

// File: rtl/freq_div_hold.sv
// freq_div_hold: one-entry divisor holding register with valid/ready handshake and clamp
// Ports: clk/rst_n clock and sync active-low reset; div_in/div_valid/div_ready request handshake;
//   apply empties the register; div_hold the clamped divisor waiting to be applied.
module freq_div_hold
  import freq_div_pkg::*;
#(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_valid,
  input  logic             apply,
  output logic             div_ready,
  output logic [DIV_W-1:0] div_hold
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_ready <= 1'b1;
      div_hold  <= '0;
    end else if (apply) begin
      div_ready <= 1'b1;
    end else if (div_valid && div_ready) begin
      div_ready <= 1'b0;
      div_hold  <= DIV_W'(clamp_div(32'(div_in)));
    end
  end
endmodule

// File: rtl/freq_divider_prog.sv
// freq_divider_prog: programmable glitch-free clock divider with period tick and run/stop control
// Ports: clk_in/rst_n clock and sync active-low reset; en run request;
//   div_in/div_valid/div_ready divisor handshake; div_active divisor of current/next period;
//   clk_out divided clock; tick one-cycle period-start pulse; running FSM in RUN or STOPPING.
module freq_divider_prog
  import freq_div_pkg::*;
#(
  parameter int DIV_W       = 24,
  parameter int DEFAULT_DIV = 1000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic [DIV_W-1:0] div_active,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);
  state_t state, state_nx;
  logic [DIV_W-1:0] cnt, div_hold;
  logic act, last, apply;
  assign act  = state != IDLE;
  assign last = act && (cnt == div_active - DIV_W'(1));
  // idle takes a waiting divisor at once; otherwise only at the edge that starts a period
  assign apply = !div_ready && (!act || last);
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = en ? RUN : IDLE;
    else if (state == RUN) state_nx = en ? RUN : (last ? IDLE : STOPPING);
    else state_nx = last ? IDLE : (en ? RUN : STOPPING);
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      div_active <= DIV_W'(DEFAULT_DIV);
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      running    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (last || !act) ? '0 : cnt + DIV_W'(1);
      if (apply) div_active <= div_hold;
      // outputs register the cycle's own state, so a whole period is always emitted before idling
      clk_out <= act && (cnt < div_active - (div_active >> 1));
      tick    <= act && (cnt == '0);
      running <= act;
    end
  end
  freq_div_hold #(.DIV_W(DIV_W)) u_hold (
    .clk(clk_in),
    .rst_n(rst_n),
    .div_in(div_in),
    .div_valid(div_valid),
    .apply(apply),
    .div_ready(div_ready),
    .div_hold(div_hold)
  );
endmodule

// File: tb/tb_freq_divider_prog.sv
// tb_freq_divider_prog: directed scenarios plus randomized run against a period-level reference model
module tb_freq_divider_prog;
  logic clk_in = 1'b0;
  logic rst_n, en, div_valid;
  logic [23:0] div_in;
  logic div_ready, clk_out, tick, running;
  logic [23:0] div_active;
  int checks = 0;
  int errors = 0;
  bit sb_on = 1'b0;

  freq_divider_prog dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .en(en),
    .div_in(div_in),
    .div_valid(div_valid),
    .div_ready(div_ready),
    .div_active(div_active),
    .clk_out(clk_out),
    .tick(tick),
    .running(running)
  );

  always #5 clk_in = ~clk_in;

  int m_D, m_pos, m_pend;
  bit m_on, m_stop;
  logic e_clk, e_tick, e_run;
  logic [27:0] exp_v;

  // reference: a period of m_D cycles, position m_pos, a stop request remembered for the period
  always @(posedge clk_in) begin : model
    bit lc;
    int d_n, pe_n;
    if (!rst_n) begin
      m_D <= 1000; m_pos <= 0; m_pend <= -1; m_on <= 0; m_stop <= 0;
      e_clk <= 0; e_tick <= 0; e_run <= 0;
    end else begin
      lc = m_on && (m_pos == m_D - 1);
      e_clk <= m_on && (m_pos < (m_D + 1) / 2);
      e_tick <= m_on && (m_pos == 0);
      e_run <= m_on;
      d_n = m_D;
      pe_n = m_pend;
      if (m_pend >= 0 && (!m_on || lc)) begin d_n = m_pend; pe_n = -1; end
      else if (div_valid && m_pend < 0) pe_n = (div_in < 2) ? 2 : int'(div_in);
      m_D <= d_n;
      m_pend <= pe_n;
      if (!m_on) begin m_on <= en; m_pos <= 0; m_stop <= 0; end
      else if (lc) begin m_on <= en && !m_stop; m_pos <= 0; m_stop <= 0; end
      else begin m_pos <= m_pos + 1; m_stop <= !en; end
    end
  end

  assign exp_v = {e_clk, e_tick, e_run, m_pend < 0, m_D[23:0]};

  always @(negedge clk_in) begin
    if (sb_on) begin
      checks++;
      if ({clk_out, tick, running, div_ready, div_active} !== exp_v) begin
        errors++;
        if (errors < 20)
          $display("FAIL model t=%0t got clk/tick/run/rdy/div %b%b%b%b/%0d exp %b/%0d", $time,
                   clk_out, tick, running, div_ready, div_active, exp_v[27:24], exp_v[23:0]);
      end
    end
  end

  task automatic load(input int v);
    int n = 0;
    while (div_ready !== 1'b1 && n < 3000) begin @(negedge clk_in); n++; end
    if (div_ready !== 1'b1) begin checks++; errors++; $display("FAIL load_timeout ready %b exp 1", div_ready); end
    div_in = 24'(v);
    div_valid = 1'b1;
    @(negedge clk_in);
    div_valid = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (m_pos != p && n < 3000) begin @(negedge clk_in); n++; end
    if (m_pos != p) begin checks++; errors++; $display("FAIL wait_pos pos %0d exp %0d", m_pos, p); end
  endtask

  task automatic stop_wait();
    int n = 0;
    en = 1'b0;
    while (running !== 1'b0 && n < 3000) begin @(negedge clk_in); n++; end
    if (running !== 1'b0) begin checks++; errors++; $display("FAIL stop_timeout running %b exp 0", running); end
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    int ts[$];
    int hi = 0;
    rst_n = 1'b0; en = 1'b1; div_valid = 1'b0; div_in = '0;
    repeat (2) @(negedge clk_in);
    sb_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      checks++;
      if ({clk_out, tick, running, div_ready} !== 4'b0001 || div_active !== 24'd1000) begin
        errors++;
        $display("FAIL reset_vals got %b%b%b%b/%0d exp 0001/1000", clk_out, tick, running, div_ready, div_active);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk_in);
      if (tick === 1'b1) ts.push_back(i);
      if (ts.size() == 1 && clk_out === 1'b1) hi++;
    end
    checks++;
    if (ts.size() < 3 || ts[0] != 1 || ts[1] - ts[0] != 1000 || ts[2] - ts[1] != 1000) begin
      errors++;
      $display("FAIL default_ticks got n=%0d first=%0d exp first=1 spacing 1000", ts.size(), ts.size() ? ts[0] : -1);
    end
    checks++;
    if (hi != 500) begin errors++; $display("FAIL default_high got %0d exp 500", hi); end
    stop_wait();
  endtask

  task automatic test_div2();
    load(2);
    repeat (2) @(negedge clk_in);
    checks++;
    if (div_active !== 24'd2 || div_ready !== 1'b1) begin
      errors++; $display("FAIL idle_load got div %0d rdy %b exp 2/1", div_active, div_ready);
    end
    en = 1'b1;
    @(negedge clk_in);
    checks++;
    if (running !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL start_lat got run %b tick %b exp 0/0", running, tick); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      checks++;
      if (clk_out !== (i % 2 == 0) || tick !== (i % 2 == 0) || running !== 1'b1) begin
        errors++; $display("FAIL div2 i=%0d got clk %b tick %b run %b exp %b", i, clk_out, tick, running, i % 2 == 0);
      end
    end
    stop_wait();
  endtask

  task automatic test_div5();
    load(5);
    repeat (2) @(negedge clk_in);
    en = 1'b1;
    @(negedge clk_in);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_in);
      checks++;
      if (clk_out !== (i % 5 < 3) || tick !== (i % 5 == 0)) begin
        errors++; $display("FAIL div5 i=%0d got clk %b tick %b exp %b %b", i, clk_out, tick, i % 5 < 3, i % 5 == 0);
      end
    end
    stop_wait();
  endtask

  task automatic test_change();
    int ts[$];
    load(4);
    repeat (2) @(negedge clk_in);
    en = 1'b1;
    @(negedge clk_in);
    wait_pos(1);
    div_in = 24'd6; div_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tick === 1'b1) ts.push_back(i);
      if (i == 1 || i == 2 || i == 3) begin
        checks++;
        if (div_ready !== (i == 3)) begin errors++; $display("FAIL ready_window i=%0d got %b exp %b", i, div_ready, i == 3); end
      end
      @(negedge clk_in);
      div_valid = 1'b0;
    end
    checks++;
    if (ts.size() < 4 || ts[1] - ts[0] != 4 || ts[2] - ts[1] != 6 || ts[3] - ts[2] != 6) begin
      errors++; $display("FAIL change_mid got n=%0d exp spacing 4,6,6", ts.size());
    end
    ts.delete();
    wait_pos(5);
    div_in = 24'd4; div_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tick === 1'b1) ts.push_back(i);
      @(negedge clk_in);
      div_valid = 1'b0;
    end
    checks++;
    if (ts.size() < 3 || ts[1] - ts[0] != 6 || ts[2] - ts[1] != 4) begin
      errors++; $display("FAIL change_last got n=%0d d0=%0d exp spacing 6,4", ts.size(), ts.size() > 1 ? ts[1] - ts[0] : -1);
    end
    stop_wait();
  endtask

  task automatic test_stop();
    int ts[$];
    load(8);
    repeat (2) @(negedge clk_in);
    en = 1'b1;
    @(negedge clk_in);
    wait_pos(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (running !== (i < 7) || clk_out !== (i < 3) || tick !== 1'b0) begin
        errors++; $display("FAIL stop i=%0d got run %b clk %b tick %b exp %b %b 0", i, running, clk_out, tick, i < 7, i < 3);
      end
      @(negedge clk_in);
    end
    en = 1'b1;
    @(negedge clk_in);
    wait_pos(2);
    en = 1'b0;
    wait_pos(5);
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tick === 1'b1) ts.push_back(i);
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL resume_run i=%0d got %b exp 1", i, running); end
      @(negedge clk_in);
    end
    checks++;
    if (ts.size() != 2 || ts[0] != 4 || ts[1] != 12) begin
      errors++; $display("FAIL resume_ticks got n=%0d first=%0d exp 4,12", ts.size(), ts.size() ? ts[0] : -1);
    end
    load(0);
    repeat (20) @(negedge clk_in);
    checks++;
    if (div_active !== 24'd2) begin errors++; $display("FAIL clamp got %0d exp 2", div_active); end
    stop_wait();
  endtask

  task automatic test_reset_mid();
    load(10);
    repeat (2) @(negedge clk_in);
    en = 1'b1;
    @(negedge clk_in);
    load(7);
    wait_pos(6);
    checks++;
    if (div_ready !== 1'b0) begin errors++; $display("FAIL pending got rdy %b exp 0", div_ready); end
    rst_n = 1'b0; en = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({clk_out, tick, running, div_ready} !== 4'b0001 || div_active !== 24'd1000) begin
        errors++; $display("FAIL reset_mid i=%0d got %b%b%b%b/%0d exp 0001/1000", i, clk_out, tick, running, div_ready, div_active);
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      if ($urandom_range(0, 19) == 0) en = ~en;
      div_valid = ($urandom_range(0, 7) == 0);
      div_in = ($urandom_range(0, 9) == 0) ? 24'($urandom_range(0, 40)) : 24'($urandom_range(0, 12));
      rst_n = ($urandom_range(0, 499) != 0);
    end
    div_valid = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    checks++;
    if (div_active !== 24'(m_D)) begin errors++; $display("FAIL random_div got %0d exp %0d", div_active, m_D); end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_div5();
    test_change();
    test_stop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_divider_prog.md
# freq_divider_prog

Programmable, glitch-free clock divider generating a near-50 % duty `clk_out` and a one-cycle `tick` per output period from `clk_in`. It is the successor to the fixed decade divider in the DDFS path, and drives the DAC sample strobe and any derived low-rate clocks. The divisor is any integer from 2 to 2^DIV_W−1, loaded through a valid/ready handshake. A new divisor takes effect only on a period boundary. Run/stop is controlled by `en`, and stopping never truncates a period.

## Interface
- `DIV_W`, 24: divisor and counter width.
- `DEFAULT_DIV`, 1000: divisor active after reset (≥2).
- `clk_in`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  run request.
- `div_in`  in  DIV_W  requested divisor.
- `div_valid`  in  1  `div_in` valid.
- `div_ready`  out  1  divisor holding register empty.
- `div_active`  out  DIV_W  divisor of the current/next period.
- `clk_out`  out  1  divided clock (registered).
- `tick`  out  1  one-cycle pulse at each period start (registered).
- `running`  out  1  FSM in RUN or STOPPING.

## Operation
- FSM states:
  - IDLE → RUN when `en`=1.
  - RUN → STOPPING when `en`=0 and the current cycle is not the last of the period.
  - RUN → IDLE when `en`=0 on the last cycle.
  - STOPPING → IDLE on the last cycle of the period.
  - STOPPING → RUN if `en` returns to 1 before the last cycle. The period continues uninterrupted.
- Counter `cnt` runs 0..D−1, where D = `div_active`. Cycle with `cnt`=D−1 is the "last cycle". The following cycle is the boundary: `cnt`=0.
- `clk_out`=1 while `cnt` < ceil(D/2), otherwise 0.
  - Even D gives 50 % duty.
  - Odd D is high one cycle longer than low.
- `tick`=1 exactly when `cnt`=0 in RUN or STOPPING.
- In IDLE: `clk_out`=0, `tick`=0, `cnt` held at 0.
- Divisor handshake:
  - Transfer occurs when `div_valid` & `div_ready`.
  - `div_in` < 2 is clamped to 2 on acceptance.
  - After a transfer, the holding register is full and `div_ready`=0.
- Divisor apply:
  - In IDLE, a full holding register loads `div_active` on the next edge, and the register empties.
  - In RUN/STOPPING, it loads at the edge that begins a new period.
  - A divisor accepted in the last cycle of a period does not apply at that boundary. It applies at the following boundary.
- Reset mid-operation: all state returns to reset values and the pending divisor is discarded.

## Timing
- Reset values:
  - `clk_out`=0, `tick`=0, `running`=0, `div_ready`=1.
  - `div_active`=DEFAULT_DIV, `cnt`=0, state IDLE.
- Start latency: `en` sampled high at edge k (in IDLE) gives `clk_out`=1, `tick`=1, `running`=1 after edge k+1.
- Output period: exactly D cycles of `clk_in`. High phase is ceil(D/2) cycles.
- Stop: the last high→low→(period end) sequence completes. `running` drops after the edge that would start the next period. `clk_out` is already 0 at that point.
- No glitches or runt phases:
  - Every `clk_out` high phase is exactly ceil(D/2) cycles of the D in force at its period start.
  - Every low phase is exactly floor(D/2) cycles of that same D.
- `div_ready` returns to 1 in the cycle after the apply edge.

## Structure
- Package `freq_div_pkg`:
  - State enum {IDLE, RUN, STOPPING}.
  - `MIN_DIV`=2.
  - Clamp function `clamp_div`.
- Sub-module `freq_div_hold`: the one-entry holding register with the valid/ready handshake, clamp, and an `apply` input that empties it. The top module contains the FSM, counter, and output registers.

## Test plan
- Reset with `en`=1 held → `div_active`=1000, `div_ready`=1, outputs 0 during reset. After release: `tick` every 1000 cycles; `clk_out` 500 high / 500 low.
- Load 2 in IDLE, then `en`=1 → `clk_out` 1,0,1,0… and `tick` every 2nd cycle, first pulse 1 cycle after `en` is sampled.
- Load 5 → `clk_out` pattern 1,1,1,0,0 repeating; `tick` on the first cycle of each 5-cycle group.
- Running at D=4, load 6 at `cnt`=1 → current period still 4 cycles. Next period 6 cycles (3 high / 3 low). `div_ready`=0 from acceptance until the apply edge. Separately, load at `cnt`=3 → applies one period later.
- Running at D=8, drop `en` at `cnt`=2 → period completes (4 high / 4 low), then `running`=0 and `clk_out`=0. Re-raise `en` at `cnt`=5 → no gap, next period normal. `div_in`=0 → `div_active`=2.
- Running at D=10 with a pending divisor, assert `rst_n`=0 at `cnt`=6 → next cycle all reset values. Pending discarded: `div_active`=1000, `div_ready`=1.
